// File: rtl/layer_batch_sequencer.sv
// Per-layer batch sequencer: clears the output BRAMs, then steps each batch through load, compute and drain.
// Optional watchdog is built only when SEQ_WATCHDOG_EN is defined.
module layer_batch_sequencer #(
   parameter int O_ADDR_W     = 9,
   parameter int O_DEPTH      = 512,
   parameter int L0_BATCHES   = 8,
   parameter int L1_BATCHES   = 4,
   parameter int DRAIN_CYCLES = 4,
   parameter int WDT_LIMIT    = 65535
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                start,
   input  logic [1:0]          layer_id_in,
   input  logic                abort,
   input  logic                weight_write_done,
   input  logic                ifmap_write_done,
   input  logic                compute_done,
   input  logic                stream_done,
   output logic                clr_en,
   output logic [O_ADDR_W-1:0] clr_addr,
   output logic                compute_start,
   output logic                stream_start,
   output logic                batch_done,
   output logic                layer_done,
   output logic                busy,
   output logic [1:0]          layer_id,
   output logic [2:0]          batch_id,
   output logic                err_bad_layer,
   output logic                timeout
);

   // state     | meaning
   // IDLE      | waiting for start
   // CLEAR     | sweeping the output BRAMs with zero writes
   // WAIT_LOAD | waiting for both weight and ifmap loads
   // COMPUTE   | compute launched, waiting for compute_done
   // DRAIN     | accumulation flush after compute
   // STREAM    | output manager streaming results out
   // DONE      | layer_done pulse, back to IDLE next
   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_WAIT_LOAD, S_COMPUTE, S_DRAIN, S_STREAM, S_DONE
   } state_t;

   localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRN_W-1:0]    DRN_LOAD = DRN_W'(DRAIN_CYCLES - 1);
   localparam logic [O_ADDR_W-1:0] CLR_LAST = O_ADDR_W'(O_DEPTH - 1);
   localparam logic [2:0]          L0_LAST  = 3'(L0_BATCHES - 1);
   localparam logic [2:0]          L1_LAST  = 3'(L1_BATCHES - 1);

   state_t              state_q, state_d;
   logic                clr_en_q, clr_en_d;
   logic [O_ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic                cs_q, cs_d;
   logic                ss_q, ss_d;
   logic                bd_q, bd_d;
   logic                ld_q, ld_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;
   logic [1:0]          layer_id_q, layer_id_d;
   logic [2:0]          batch_id_q, batch_id_d;
   logic [2:0]          last_q, last_d;
   logic                w_ok_q, w_ok_d;
   logic                i_ok_q, i_ok_d;
   logic [DRN_W-1:0]    drn_q, drn_d;
   logic                w_seen, i_seen;

`ifdef SEQ_WATCHDOG_EN
   localparam logic [15:0] WDT_TC = 16'(WDT_LIMIT - 1);
   logic [15:0] wdt_q, wdt_d;
   logic        timeout_q, timeout_d;
   logic        wdt_state;
`endif

   // A done pulse in the same cycle as the check counts as already loaded.
   assign w_seen = w_ok_q | weight_write_done;
   assign i_seen = i_ok_q | ifmap_write_done;

   always_comb begin
      state_d    = state_q;
      clr_en_d   = 1'b0;
      clr_addr_d = clr_addr_q;
      cs_d       = 1'b0;
      ss_d       = 1'b0;
      bd_d       = 1'b0;
      ld_d       = 1'b0;
      err_d      = 1'b0;
      layer_id_d = layer_id_q;
      batch_id_d = batch_id_q;
      last_d     = last_q;
      w_ok_d     = w_ok_q;
      i_ok_d     = i_ok_q;
      drn_d      = drn_q;
`ifdef SEQ_WATCHDOG_EN
      timeout_d  = timeout_q;
      wdt_d      = wdt_q;
      wdt_state  = 1'b0;
`endif

      if (state_q != S_IDLE) begin
         w_ok_d = w_seen;
         i_ok_d = i_seen;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (layer_id_in[1]) begin
                  err_d = 1'b1;
               end else begin
                  layer_id_d = layer_id_in;
                  last_d     = layer_id_in[0] ? L1_LAST : L0_LAST;
                  batch_id_d = 3'd0;
                  clr_en_d   = 1'b1;
                  clr_addr_d = '0;
                  state_d    = S_CLEAR;
`ifdef SEQ_WATCHDOG_EN
                  timeout_d  = 1'b0;
`endif
               end
            end
         end
         S_CLEAR: begin
            if (clr_addr_q == CLR_LAST) begin
               state_d = S_WAIT_LOAD;
            end else begin
               clr_en_d   = 1'b1;
               clr_addr_d = clr_addr_q + O_ADDR_W'(1);
            end
         end
         S_WAIT_LOAD: begin
            if (w_seen && i_seen) begin
               cs_d    = 1'b1;
               w_ok_d  = 1'b0;
               i_ok_d  = 1'b0;
               state_d = S_COMPUTE;
            end
         end
         S_COMPUTE: begin
            if (compute_done) begin
               drn_d   = DRN_LOAD;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drn_q == '0) begin
               if (batch_id_q == last_q) begin
                  ss_d    = 1'b1;
                  state_d = S_STREAM;
               end else begin
                  bd_d       = 1'b1;
                  batch_id_d = batch_id_q + 3'd1;
                  state_d    = S_WAIT_LOAD;
               end
            end else begin
               drn_d = drn_q - DRN_W'(1);
            end
         end
         S_STREAM: begin
            if (stream_done) begin
               ld_d    = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

`ifdef SEQ_WATCHDOG_EN
      wdt_state = (state_q == S_WAIT_LOAD) || (state_q == S_COMPUTE) ||
                  (state_q == S_STREAM);
      // Expiry abandons the layer silently apart from the sticky flag.
      if (wdt_state && (wdt_q == WDT_TC)) begin
         state_d   = S_IDLE;
         timeout_d = 1'b1;
         cs_d      = 1'b0;
         ld_d      = 1'b0;
         w_ok_d    = 1'b0;
         i_ok_d    = 1'b0;
      end
`endif

      if (abort) begin
         state_d    = S_IDLE;
         clr_en_d   = 1'b0;
         clr_addr_d = clr_addr_q;
         cs_d       = 1'b0;
         ss_d       = 1'b0;
         bd_d       = 1'b0;
         ld_d       = 1'b0;
         err_d      = 1'b0;
         layer_id_d = layer_id_q;
         batch_id_d = batch_id_q;
         last_d     = last_q;
         w_ok_d     = 1'b0;
         i_ok_d     = 1'b0;
`ifdef SEQ_WATCHDOG_EN
         timeout_d  = timeout_q;
`endif
      end

`ifdef SEQ_WATCHDOG_EN
      if (state_d != state_q) begin
         wdt_d = '0;
      end else if (wdt_state) begin
         wdt_d = wdt_q + 16'd1;
      end
`endif

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q    <= S_IDLE;
         clr_en_q   <= 1'b0;
         clr_addr_q <= '0;
         cs_q       <= 1'b0;
         ss_q       <= 1'b0;
         bd_q       <= 1'b0;
         ld_q       <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         layer_id_q <= 2'd0;
         batch_id_q <= 3'd0;
         last_q     <= 3'd0;
         w_ok_q     <= 1'b0;
         i_ok_q     <= 1'b0;
         drn_q      <= '0;
      end else begin
         state_q    <= state_d;
         clr_en_q   <= clr_en_d;
         clr_addr_q <= clr_addr_d;
         cs_q       <= cs_d;
         ss_q       <= ss_d;
         bd_q       <= bd_d;
         ld_q       <= ld_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         layer_id_q <= layer_id_d;
         batch_id_q <= batch_id_d;
         last_q     <= last_d;
         w_ok_q     <= w_ok_d;
         i_ok_q     <= i_ok_d;
         drn_q      <= drn_d;
      end
   end

`ifdef SEQ_WATCHDOG_EN
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wdt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdt_q     <= wdt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign clr_en        = clr_en_q;
   assign clr_addr      = clr_addr_q;
   assign compute_start = cs_q;
   assign stream_start  = ss_q;
   assign batch_done    = bd_q;
   assign layer_done    = ld_q;
   assign busy          = busy_q;
   assign layer_id      = layer_id_q;
   assign batch_id      = batch_id_q;
   assign err_bad_layer = err_q;

endmodule

// File: doc/layer_batch_sequencer.md
Name: layer_batch_sequencer

Overview:
- Per-layer sequencer for the transpose-convolution datapath.
- On start, it clears the output BRAMs and then runs each batch in turn: it waits for the weight and ifmap loads, launches compute, and waits for the accumulation drain.
- After the last batch it hands the output BRAMs to the output stream manager.
- It sits between the AXI load wrappers, the control top and the output stream manager, and replaces the ad-hoc batch/layer glue.

Parameters:
- O_ADDR_W, 9, output BRAM address width
- O_DEPTH, 512, output BRAM words swept during clear
- L0_BATCHES, 8, batches in layer 0
- L1_BATCHES, 4, batches in layer 1
- DRAIN_CYCLES, 4, post-compute cycles before a batch is considered complete (psum/accumulation flush)
- WDT_LIMIT, 65535, watchdog cycle limit (only with SEQ_WATCHDOG_EN)

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- start  in  1  begin layer (sampled in IDLE only)
- layer_id_in  in  2  layer to run; 0 or 1 valid
- abort  in  1  soft abort, any state
- weight_write_done  in  1  pulse: weight batch loaded
- ifmap_write_done  in  1  pulse: ifmap batch loaded
- compute_done  in  1  pulse from control top: compute finished
- stream_done  in  1  pulse from output manager: last word sent
- clr_en  out  1  output BRAM clear write enable
- clr_addr  out  O_ADDR_W  clear address
- compute_start  out  1  one-cycle compute launch
- stream_start  out  1  one-cycle output stream launch
- batch_done  out  1  one-cycle pulse per completed non-final batch
- layer_done  out  1  one-cycle pulse at layer end
- busy  out  1  high in every state except IDLE
- layer_id  out  2  latched layer
- batch_id  out  3  current batch index
- err_bad_layer  out  1  one-cycle pulse on invalid layer_id_in
- timeout  out  1  sticky watchdog flag

Behaviour:
- Interface: one clock, aclk; reset aresetn is synchronous, active-low.
- Reset: state IDLE. All outputs are 0, and the internal counters and load flags are 0. Reset has priority over everything, including mid-clear or mid-compute.
- All outputs are registered; pulses last exactly one cycle.
- IDLE, start=1, layer_id_in in {0,1}:
  - Latch layer_id.
  - Set last = L0_BATCHES-1 or L1_BATCHES-1.
  - Set batch_id=0.
  - Go to CLEAR.
- IDLE, start=1, layer_id_in in {2,3}: pulse err_bad_layer and stay in IDLE.
- start outside IDLE is ignored.
- CLEAR:
  - clr_en=1, with clr_addr running 0..O_DEPTH-1 on consecutive cycles; exactly O_DEPTH cycles.
  - After the final address, clr_en=0 and go to WAIT_LOAD.
  - clr_addr holds its last value when idle.
- Load flags w_ok and i_ok are sticky. They are set by the done pulses in any busy state, including CLEAR and COMPUTE, so early loads for the next batch are not lost.
- WAIT_LOAD: when w_ok & i_ok (including a pulse arriving in the same cycle), pulse compute_start next cycle, clear both flags and go to COMPUTE.
- COMPUTE: wait for compute_done, which is accepted only in this state (ignored elsewhere). Then go to DRAIN.
- DRAIN: count DRAIN_CYCLES cycles, then:
  - If batch_id==last: pulse stream_start and go to STREAM.
  - Otherwise: pulse batch_done, increment batch_id and go to WAIT_LOAD.
- batch_id never wraps; it stays at last through STREAM/DONE.
- STREAM: wait for stream_done, then go to DONE.
- DONE: pulse layer_done, then go to IDLE (busy=0). batch_id and layer_id hold until the next start.
- abort=1 in any state:
  - Next state is IDLE; clr_en=0; flags cleared; no pulses issued that cycle.
  - Downstream blocks are responsible for their own abort.
- Simultaneous abort and start in IDLE: abort wins.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- When defined:
  - A 16-bit counter resets on every state change and increments in WAIT_LOAD, COMPUTE and STREAM.
  - On reaching WDT_LIMIT: set timeout (sticky until reset or the next accepted start), go to IDLE and issue no layer_done.
- When undefined: no counter is synthesized, timeout is tied to 0, and the sequencer waits indefinitely.

Test Plan:
- Reset then start with layer_id_in=0, with loads/compute_done/stream_done returned promptly:
  - clr_en high for exactly 512 cycles, addr 0..511.
  - 8 compute_start pulses; 7 batch_done pulses with batch_id 0→7.
  - 1 stream_start, then layer_done; busy falls the cycle after layer_done.
- Layer 1 run: exactly 4 compute_start pulses, 3 batch_done pulses, final batch_id=3.
- Early loads: weight_write_done during CLEAR and ifmap_write_done during the previous COMPUTE → compute_start fires the cycle after WAIT_LOAD is entered, with no extra wait.
- start with layer_id_in=2 → single err_bad_layer pulse, busy stays 0, no clr_en. Start during COMPUTE → ignored, batch_id unchanged.
- abort asserted mid-CLEAR (addr 100) → next cycle IDLE, clr_en=0, no layer_done. A subsequent start restarts the clear at addr 0.
- SEQ_WATCHDOG_EN with WDT_LIMIT=1000, compute_done withheld → timeout=1 after 1000 COMPUTE cycles, state IDLE, no stream_start. Without the macro, the same stimulus leaves busy=1 indefinitely and timeout=0.
